// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl shared types: address/MESI types, controller states,
// default parameters and a MESI helper.
package cache_ctrl_pkg;

  typedef struct packed {
    logic [15:0] Page_reference;
    logic [7:0]  Index;
  } Taddress;

  typedef enum logic [1:0] {
    INVALID   = 2'b00,
    SHARED    = 2'b01,
    EXCLUSIVE = 2'b10,
    MODIFIED  = 2'b11
  } Tmesi_state;

  typedef enum logic [3:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    WB,
    FETCH,
    FILL,
    WRITE,
    RESP,
    BYPASS
  } Tctrl_state;

  // Index the array does not store; also used by the array's bounds check.
  localparam logic [7:0] UNCACHED_INDEX_DEF = 8'hFF;
  localparam int         MEM_TIMEOUT_DEF    = 255;

  function automatic logic is_valid(Tmesi_state s);
    return s != INVALID;
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU request/response and memory bus bundle for cache_ctrl.
// slave = controller side, master = CPU + memory environment.
interface cache_ctrl_if;
  import cache_ctrl_pkg::*;

  logic        cpu_req_valid;
  logic        cpu_req_ready;
  Taddress     cpu_req_addr;
  logic        cpu_req_we;
  logic [31:0] cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        cpu_resp_err;
  logic        mem_req;
  logic        mem_we;
  Taddress     mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_shared;
  logic        bus_upgrade;

  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_req_we,
    input  cpu_req_wdata, mem_ack, mem_rdata, mem_shared,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    output cpu_resp_err, mem_req, mem_we, mem_addr,
    output mem_wdata, bus_upgrade
  );

  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_we,
    output cpu_req_wdata, mem_ack, mem_rdata, mem_shared,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    input  cpu_resp_err, mem_req, mem_we, mem_addr,
    input  mem_wdata, bus_upgrade
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Memory wait counter: load_i clears, en_i counts, expired_o marks
// the MAX-th waiting cycle. Ports: clk, reset (sync, active-low).
module mem_timeout_ctr #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == W'(MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cache_ctrl.sv
// Request-side controller for the MESI direct-mapped cache array.
// Ports: clk/reset, bus (CPU + memory, slave), c_* array side.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int         MEM_TIMEOUT    = MEM_TIMEOUT_DEF,
  parameter logic [7:0] UNCACHED_INDEX = UNCACHED_INDEX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  cache_ctrl_if.slave bus,
  output Taddress     c_addr,
  output logic [31:0] c_wdata,
  output logic        c_we,
  output Tmesi_state  c_mesi_out,
  input  logic [31:0] c_rdata,
  input  Tmesi_state  c_mesi_in,
  input  Taddress     c_tag_addr
);

  Tctrl_state  state_q, state_d;
  Taddress     addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        shared_q, shared_d;
  logic        err_q, err_d;
  Taddress     vaddr_q, vaddr_d;
  logic [31:0] vdata_q, vdata_d;

  logic hit, expired, waiting;

  // Counter restarts on every state change, so WB->FETCH gets a fresh budget.
  assign waiting = (state_q == WB) || (state_q == FETCH)
                || (state_q == BYPASS);

  mem_timeout_ctr #(.MAX(MEM_TIMEOUT)) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .load_i   (state_d != state_q),
    .en_i     (waiting),
    .expired_o(expired)
  );

  assign hit = is_valid(c_mesi_in)
            && (c_tag_addr.Page_reference == addr_q.Page_reference);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    shared_d = shared_q;
    err_d    = err_q;
    vaddr_d  = vaddr_q;
    vdata_d  = vdata_q;

    bus.cpu_req_ready  = 1'b0;
    bus.cpu_resp_valid = 1'b0;
    bus.cpu_resp_rdata = '0;
    bus.cpu_resp_err   = 1'b0;
    bus.mem_req        = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    bus.bus_upgrade    = 1'b0;
    c_addr     = (state_q == IDLE) ? '0 : addr_q;
    c_wdata    = '0;
    c_we       = 1'b0;
    c_mesi_out = INVALID;

    unique case (state_q)
      IDLE: begin
        bus.cpu_req_ready = 1'b1;
        if (bus.cpu_req_valid) begin
          addr_d  = bus.cpu_req_addr;
          we_d    = bus.cpu_req_we;
          wdata_d = bus.cpu_req_wdata;
          err_d   = 1'b0;
          state_d = (bus.cpu_req_addr.Index == UNCACHED_INDEX)
                  ? BYPASS : LOOKUP;
        end
      end
      LOOKUP: state_d = COMPARE;
      COMPARE: begin
        vaddr_d = c_tag_addr;
        vdata_d = c_rdata;
        if (hit) begin
          if (!we_q) begin
            rdata_d = c_rdata;
            state_d = RESP;
          end else begin
            state_d = WRITE;
            if (c_mesi_in == SHARED) begin
              bus.bus_upgrade = 1'b1;
              bus.mem_addr    = addr_q;
            end
          end
        end else if (c_mesi_in == MODIFIED) begin
          state_d = WB;
        end else begin
          state_d = we_q ? WRITE : FETCH;
        end
      end
      WB: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = vaddr_q;
        bus.mem_wdata = vdata_q;
        if (bus.mem_ack) begin
          state_d = we_q ? WRITE : FETCH;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      FETCH: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_q;
        if (bus.mem_ack) begin
          rdata_d  = bus.mem_rdata;
          shared_d = bus.mem_shared;
          state_d  = FILL;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      FILL: begin
        c_we       = 1'b1;
        c_wdata    = rdata_q;
        c_mesi_out = shared_q ? SHARED : EXCLUSIVE;
        state_d    = RESP;
      end
      WRITE: begin
        c_we       = 1'b1;
        c_wdata    = wdata_q;
        c_mesi_out = MODIFIED;
        state_d    = RESP;
      end
      BYPASS: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = we_q ? wdata_q : '0;
        if (bus.mem_ack) begin
          if (!we_q) rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.cpu_resp_valid = 1'b1;
        bus.cpu_resp_rdata = rdata_q;
        bus.cpu_resp_err   = err_q;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      shared_q <= 1'b0;
      err_q    <= 1'b0;
      vaddr_q  <= '0;
      vdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      shared_q <= shared_d;
      err_q    <= err_d;
      vaddr_q  <= vaddr_d;
      vdata_q  <= vdata_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl with a behavioural
// registered-read MESI array and a latency-programmable memory.
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  Taddress     c_addr;
  logic [31:0] c_wdata;
  logic        c_we;
  Tmesi_state  c_mesi_out;
  logic [31:0] c_rdata;
  Tmesi_state  c_mesi_in;
  Taddress     c_tag_addr;

  cache_ctrl_if bus();

  cache_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_we      (c_we),
    .c_mesi_out(c_mesi_out),
    .c_rdata   (c_rdata),
    .c_mesi_in (c_mesi_in),
    .c_tag_addr(c_tag_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model
  logic [15:0] tag_m  [256];
  Tmesi_state  mesi_m [256];
  logic [31:0] data_m [256];
  logic        pl_en;
  logic [7:0]  pl_idx;
  Tmesi_state  pl_mesi;
  logic [15:0] pl_tag;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      tag_m[pl_idx]  <= pl_tag;
      mesi_m[pl_idx] <= pl_mesi;
      data_m[pl_idx] <= pl_data;
    end else if (c_we) begin
      tag_m[c_addr.Index]  <= c_addr.Page_reference;
      mesi_m[c_addr.Index] <= c_mesi_out;
      data_m[c_addr.Index] <= c_wdata;
    end
    c_rdata    <= data_m[c_addr.Index];
    c_mesi_in  <= mesi_m[c_addr.Index];
    c_tag_addr <= {tag_m[c_addr.Index], c_addr.Index};
  end

  // Monitor + memory responder
  typedef struct {
    logic        we;
    Taddress     addr;
    logic [31:0] wdata;
  } mlog_t;

  mlog_t       log_q[$];
  int          n_cwe, n_mreq, n_resp, n_upg;
  Taddress     upg_addr;
  int          mem_lat;
  logic [31:0] mem_rd;
  logic        mem_sh;
  int          req_cnt;

  always @(negedge clk) begin
    if (c_we) n_cwe++;
    if (bus.mem_req) n_mreq++;
    if (bus.cpu_resp_valid) n_resp++;
    if (bus.bus_upgrade) begin
      n_upg++;
      upg_addr = bus.mem_addr;
    end
    bus.mem_ack = 1'b0;
    if (bus.mem_req && reset) begin
      req_cnt++;
      if (mem_lat != 0 && req_cnt >= mem_lat) begin
        bus.mem_ack    = 1'b1;
        bus.mem_rdata  = mem_rd;
        bus.mem_shared = mem_sh;
        log_q.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
        req_cnt = 0;
      end
    end else begin
      req_cnt = 0;
    end
  end

  int checks;
  int failures;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input Tmesi_state m,
                         input logic [15:0] tg, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_mesi = m;
    pl_tag = tg; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  int s_cwe, s_mreq, s_upg, s_log;

  task automatic do_req(input logic [23:0] a, input logic w,
                        input logic [31:0] d, output int lat,
                        output logic [31:0] rd, output logic er);
    @(negedge clk);
    s_cwe = n_cwe; s_mreq = n_mreq; s_upg = n_upg;
    s_log = log_q.size();
    chk("ready_before_req", bus.cpu_req_ready, 1);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = a;
    bus.cpu_req_we    = w;
    bus.cpu_req_wdata = d;
    @(posedge clk);
    #1 bus.cpu_req_valid = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (bus.cpu_resp_valid) begin
        lat = i;
        rd  = bus.cpu_resp_rdata;
        er  = bus.cpu_resp_err;
        break;
      end
    end
    if (lat == 0) begin
      failures++;
      checks++;
      $display("FAIL resp_timeout: got none expected cpu_resp_valid");
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          cwe;
    int          upg;
    int          mreq;
  } vec_t;

  vec_t        tv[4];
  int          lat;
  logic [31:0] rd;
  logic        er;
  int          k, r0;

  initial begin
    checks = 0; failures = 0;
    pl_en = 1'b0; mem_lat = 0; mem_rd = '0; mem_sh = 1'b0;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_we    = 1'b0;
    bus.cpu_req_wdata = '0;
    reset = 1'b0;

    tv[0] = '{24'h1234_10, 1'b0, 32'h0, 32'hDEADBEEF, 3, 0, 0, 0};
    tv[1] = '{24'h0042_30, 1'b0, 32'h0, 32'h0BADF00D, 3, 0, 0, 0};
    tv[2] = '{24'h00AA_40, 1'b0, 32'h0, 32'h55AA55AA, 3, 0, 0, 0};
    tv[3] = '{24'h7777_50, 1'b1, 32'h12345678, 32'h0, 4, 1, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.cpu_req_ready, 1);
    chk("rst_resp_valid", bus.cpu_resp_valid, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_c_we", c_we, 0);
    chk("rst_c_mesi_out", c_mesi_out, INVALID);
    chk("rst_c_addr", c_addr, 0);
    reset = 1'b1;

    preload(8'h10, EXCLUSIVE, 16'h1234, 32'hDEADBEEF);
    preload(8'h30, SHARED,    16'h0042, 32'h0BADF00D);
    preload(8'h40, MODIFIED,  16'h00AA, 32'h55AA55AA);
    preload(8'h50, EXCLUSIVE, 16'h7777, 32'h00000001);

    for (int i = 0; i < 4; i++) begin
      do_req(tv[i].addr, tv[i].we, tv[i].wdata, lat, rd, er);
      chk($sformatf("tv%0d_lat", i), lat, tv[i].lat);
      if (!tv[i].we) chk($sformatf("tv%0d_rdata", i), rd, tv[i].rdata);
      chk($sformatf("tv%0d_err", i), er, 0);
      chk($sformatf("tv%0d_cwe", i), n_cwe - s_cwe, tv[i].cwe);
      chk($sformatf("tv%0d_upg", i), n_upg - s_upg, tv[i].upg);
      chk($sformatf("tv%0d_mreq", i), n_mreq - s_mreq, tv[i].mreq);
    end
    chk("wrhit_E_mesi", mesi_m[8'h50], MODIFIED);
    chk("wrhit_E_data", data_m[8'h50], 32'h12345678);

    // Write hit on SHARED -> upgrade
    preload(8'h10, SHARED, 16'h1234, 32'hDEADBEEF);
    do_req(24'h1234_10, 1'b1, 32'hCAFEF00D, lat, rd, er);
    chk("upg_lat", lat, 4);
    chk("upg_count", n_upg - s_upg, 1);
    chk("upg_addr", upg_addr, 24'h1234_10);
    chk("upg_mreq", n_mreq - s_mreq, 0);
    chk("upg_mesi", mesi_m[8'h10], MODIFIED);
    chk("upg_tag", tag_m[8'h10], 16'h1234);
    chk("upg_data", data_m[8'h10], 32'hCAFEF00D);

    // Dirty victim writeback then shared fetch
    preload(8'h20, MODIFIED, 16'h0001, 32'h11111111);
    mem_lat = 2; mem_rd = 32'h22222222; mem_sh = 1'b1;
    do_req(24'h0002_20, 1'b0, 32'h0, lat, rd, er);
    chk("wb_rdata", rd, 32'h22222222);
    chk("wb_err", er, 0);
    chk("wb_nlog", log_q.size() - s_log, 2);
    if (log_q.size() - s_log == 2) begin
      chk("wb_we", log_q[s_log].we, 1);
      chk("wb_addr", log_q[s_log].addr, 24'h0001_20);
      chk("wb_wdata", log_q[s_log].wdata, 32'h11111111);
      chk("fetch_we", log_q[s_log+1].we, 0);
      chk("fetch_addr", log_q[s_log+1].addr, 24'h0002_20);
    end
    chk("wb_line_mesi", mesi_m[8'h20], SHARED);
    chk("wb_line_tag", tag_m[8'h20], 16'h0002);
    chk("wb_line_data", data_m[8'h20], 32'h22222222);

    // Clean read miss, exclusive fill
    preload(8'h60, INVALID, 16'h0000, 32'h0);
    mem_lat = 3; mem_rd = 32'hA5A5A5A5; mem_sh = 1'b0;
    do_req(24'h0009_60, 1'b0, 32'h0, lat, rd, er);
    chk("miss_lat", lat, 7);
    chk("miss_rdata", rd, 32'hA5A5A5A5);
    chk("miss_mesi", mesi_m[8'h60], EXCLUSIVE);
    chk("miss_tag", tag_m[8'h60], 16'h0009);

    // Write miss on clean victim: no memory traffic
    preload(8'h70, EXCLUSIVE, 16'h0003, 32'h0);
    do_req(24'h0004_70, 1'b1, 32'h13572468, lat, rd, er);
    chk("wmiss_lat", lat, 4);
    chk("wmiss_mreq", n_mreq - s_mreq, 0);
    chk("wmiss_mesi", mesi_m[8'h70], MODIFIED);
    chk("wmiss_tag", tag_m[8'h70], 16'h0004);
    chk("wmiss_data", data_m[8'h70], 32'h13572468);

    // Uncached read
    mem_lat = 1; mem_rd = 32'h0F0F0F0F;
    do_req(24'h0005_FF, 1'b0, 32'h0, lat, rd, er);
    chk("byp_rd_lat", lat, 2);
    chk("byp_rd_rdata", rd, 32'h0F0F0F0F);
    chk("byp_rd_cwe", n_cwe - s_cwe, 0);
    chk("byp_rd_nlog", log_q.size() - s_log, 1);
    if (log_q.size() - s_log == 1) begin
      chk("byp_rd_we", log_q[s_log].we, 0);
      chk("byp_rd_addr", log_q[s_log].addr, 24'h0005_FF);
    end

    // Uncached write
    do_req(24'h0006_FF, 1'b1, 32'h99999999, lat, rd, er);
    chk("byp_wr_cwe", n_cwe - s_cwe, 0);
    chk("byp_wr_err", er, 0);
    chk("byp_wr_nlog", log_q.size() - s_log, 1);
    if (log_q.size() - s_log == 1) begin
      chk("byp_wr_we", log_q[s_log].we, 1);
      chk("byp_wr_addr", log_q[s_log].addr, 24'h0006_FF);
      chk("byp_wr_wdata", log_q[s_log].wdata, 32'h99999999);
    end

    // Memory never acks -> timeout
    preload(8'h80, INVALID, 16'h0055, 32'h0);
    mem_lat = 0;
    do_req(24'h0001_80, 1'b0, 32'h0, lat, rd, er);
    chk("tmo_err", er, 1);
    chk("tmo_mreq_cycles", n_mreq - s_mreq, 255);
    chk("tmo_cwe", n_cwe - s_cwe, 0);
    chk("tmo_mesi", mesi_m[8'h80], INVALID);
    chk("tmo_ready_after", bus.cpu_req_ready, 1);

    // Reset during FETCH
    preload(8'h90, INVALID, 16'h0000, 32'h0);
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 24'h0003_90;
    bus.cpu_req_we    = 1'b0;
    @(posedge clk);
    #1 bus.cpu_req_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.mem_req && k < 10);
    chk("rst_fetch_reached", bus.mem_req, 1);
    chk("rst_fetch_we", bus.mem_we, 0);
    reset = 1'b0;
    r0 = n_resp;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_mem_req", bus.mem_req, 0);
    chk("rst_mid_ready", bus.cpu_req_ready, 1);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_resp", n_resp - r0, 0);
    chk("rst_mid_mesi", mesi_m[8'h90], INVALID);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Request-side controller directly upstream of the MESI-tagged direct-mapped cache array (256 lines × 58 b, one 32-bit word per line, registered read).
- Accepts single-word CPU read/write requests over a valid/ready handshake and drives the array's addr/wdata/we/mesi_state_in.
- Decides hit/miss from the returned line, evicts Modified victims to memory, and fetches on read miss.
- Reports a bus upgrade on write-to-Shared.

Parameters:
- MEM_TIMEOUT, 255: max cycles waiting for mem_ack before aborting with cpu_resp_err.
- UNCACHED_INDEX, 8'hFF: index the array does not store; always bypassed to memory.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- cpu_req_valid  in  1  request valid
- cpu_req_ready  out  1  high only in IDLE
- cpu_req_addr  in  Taddress  {Page_reference[15:0], Index[7:0]}
- cpu_req_we  in  1  1 = write
- cpu_req_wdata  in  32  write data
- cpu_resp_valid  out  1  one-cycle completion pulse
- cpu_resp_rdata  out  32  read data, valid with cpu_resp_valid
- cpu_resp_err  out  1  timeout flag, valid with cpu_resp_valid
- c_addr  out  Taddress  to array addr
- c_wdata  out  32  to array wdata
- c_we  out  1  to array we
- c_mesi_out  out  Tmesi_state  to array mesi_state_in
- c_rdata  in  32  array rdata
- c_mesi_in  in  Tmesi_state  array cache_mesi_state
- c_tag_addr  in  Taddress  array cache_addr
- mem_req  out  1  held until mem_ack
- mem_we  out  1  1 = writeback, 0 = fetch
- mem_addr  out  Taddress  memory word address
- mem_wdata  out  32  writeback data
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  32  fetch data, valid with mem_ack
- mem_shared  in  1  sampled with fetch ack; 1 means another cache holds the line
- bus_upgrade  out  1  one-cycle pulse on write hit to SHARED; address on mem_addr

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE; internal request registers clear; timeout counter clears.
  - Outputs: cpu_req_ready=1; all other outputs 0 (c_mesi_out=INVALID).
  - Reset mid-transaction aborts it: mem_req drops the next cycle and no response is issued. Array contents are untouched.
- FSM states: IDLE, LOOKUP, COMPARE, WB, FETCH, FILL, WRITE, RESP, BYPASS.
- IDLE: on cpu_req_valid, latch addr/we/wdata and go to LOOKUP. If Index==UNCACHED_INDEX, go to BYPASS instead.
- LOOKUP: c_addr = latched addr, c_we=0. Waits one cycle for the array's registered read.
- COMPARE: hit = (c_mesi_in!=INVALID) && (c_tag_addr.Page_reference == latched Page_reference).
  - Read hit: go to RESP with rdata=c_rdata.
  - Write hit: go to WRITE. If c_mesi_in==SHARED, pulse bus_upgrade this cycle.
  - Miss with victim MODIFIED: go to WB.
  - Miss otherwise: read goes to FETCH, write goes to WRITE.
- WB: mem_req=1, mem_we=1, mem_addr=c_tag_addr (captured in COMPARE), mem_wdata=victim data. On mem_ack, read goes to FETCH, write goes to WRITE.
- FETCH: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ack, capture mem_rdata and mem_shared, then go to FILL.
- FILL: c_we=1 for one cycle, c_wdata=fetched data, c_mesi_out = SHARED if shared else EXCLUSIVE. Then go to RESP with rdata=fetched data.
- WRITE: c_we=1 for one cycle, c_wdata=latched wdata, c_mesi_out=MODIFIED. Then go to RESP. There is no fetch on a write miss (line = one word).
- BYPASS: same handshake as FETCH (read) or WB (write) on the latched addr. The array is never written. Then go to RESP.
- RESP: cpu_resp_valid=1 for exactly one cycle, then go to IDLE. No backpressure on the response.
- Latency, counted from the accepting edge to cpu_resp_valid high:
  - read hit 3 cycles;
  - write hit 4 cycles;
  - read miss, clean victim: 4 + mem latency.
- Timeout: counter runs in WB, FETCH and BYPASS and resets on state entry.
  - At MEM_TIMEOUT: drop mem_req, set cpu_resp_err=1, go to RESP.
  - The array is not written on the timeout path.
- mem_ack arriving outside WB/FETCH/BYPASS is ignored.
- c_addr holds the latched addr in all non-IDLE states.

Decomposition:
- Add to definesPkg:
  - Tctrl_state enum;
  - MESI helper function is_valid(Tmesi_state);
  - UNCACHED_INDEX constant, reused by the array's bounds check.
- Reuse the existing Taddress and Tmesi_state.
- One sub-module: mem_timeout_ctr (load/enable/expire counter).

Test Plan:
- Preload line 0x10 = {EXCLUSIVE, page 0x1234, 0xDEADBEEF}; read 0x1234_10 -> resp_valid 3 cycles after accept, rdata 0xDEADBEEF, no mem_req.
- Write 0xCAFEF00D to 0x1234_10 with the line SHARED -> bus_upgrade pulse in COMPARE; line becomes {MODIFIED, 0x1234, 0xCAFEF00D}; resp_valid at cycle 4.
- Line 0x20 = {MODIFIED, page 0x0001, 0x11111111}; read 0x0002_20 -> writeback mem_addr 0x0001_20 with data 0x11111111, then fetch 0x0002_20. mem_rdata 0x22222222 with mem_shared=1 -> line {SHARED, 0x0002, 0x22222222}; rdata 0x22222222.
- Read 0x0005_FF -> bypass fetch; array c_we never asserted; rdata = mem_rdata.
- Read miss with mem_ack withheld -> after MEM_TIMEOUT cycles mem_req drops; resp_valid with cpu_resp_err=1; line unchanged.
- Assert reset low during FETCH -> next cycle state IDLE, mem_req=0, cpu_req_ready=1; no resp_valid.
